quadrature_mixer_dump: RTL and testbench

//  Downstream consumer of the quadrature_clock I/Q outputs. Mixes a signed sample

---
 rtl/quadrature_mixer_dump.sv | 62 ++++++
 tb/tb_quadrature_mixer_dump.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/quadrature_mixer_dump.sv
// quadrature_mixer_dump: mixes signed samples with 1-bit I/Q LO phases, integrates DECIM accepted samples, dumps sums
module quadrature_mixer_dump #(
  parameter int DATA_W = 16,
  parameter int DECIM  = 16
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      lo_i,
  input  logic                                      lo_q,
  input  logic signed [DATA_W-1:0]                  din,
  input  logic                                      din_valid,
  input  logic                                      clear,
  output logic signed [DATA_W+$clog2(DECIM):0]      i_out,
  output logic signed [DATA_W+$clog2(DECIM):0]      q_out,
  output logic                                      out_valid
);
  localparam int CNT_W = $clog2(DECIM);
  localparam int ACC_W = DATA_W + CNT_W + 1;
  logic signed [DATA_W:0]  din_x;
  logic signed [ACC_W-1:0] term_i, term_q, sum_i, sum_q;
  logic signed [ACC_W-1:0] acc_i_d, acc_i_q, acc_q_d, acc_q_q;
  logic signed [ACC_W-1:0] i_out_d, i_out_q, q_out_d, q_out_q;
  logic [CNT_W-1:0]        count_d, count_q;
  logic                    out_valid_d, out_valid_q;
  logic                    dump;
  // widen before negating so -(-2^(DATA_W-1)) is representable; clear wins over a dump-cycle sample
  always_comb begin
    din_x       = {din[DATA_W-1], din};
    term_i      = ACC_W'(lo_i ? din_x : -din_x);
    term_q      = ACC_W'(lo_q ? din_x : -din_x);
    sum_i       = acc_i_q + term_i;
    sum_q       = acc_q_q + term_q;
    dump        = din_valid && !clear && (count_q == CNT_W'(DECIM - 1));
    acc_i_d     = (clear || dump) ? '0 : din_valid ? sum_i : acc_i_q;
    acc_q_d     = (clear || dump) ? '0 : din_valid ? sum_q : acc_q_q;
    count_d     = (clear || dump) ? '0 : din_valid ? count_q + 1'b1 : count_q;
    i_out_d     = dump ? sum_i : i_out_q;
    q_out_d     = dump ? sum_q : q_out_q;
    out_valid_d = dump;
  end
  // state registers; reset discards partial window and published sums at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      count_q     <= '0;
      i_out_q     <= '0;
      q_out_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      count_q     <= count_d;
      i_out_q     <= i_out_d;
      q_out_q     <= q_out_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign i_out     = i_out_q;
  assign q_out     = q_out_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_quadrature_mixer_dump.sv
// tb_quadrature_mixer_dump: table-driven scenarios, interrupt sequences and random traffic against a window-list model
module tb_quadrature_mixer_dump;
  localparam int DECIM = 16;
  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               lo_i = 1'b0, lo_q = 1'b0, din_valid = 1'b0, clear = 1'b0;
  logic signed [15:0] din = '0;
  logic signed [20:0] i_out, q_out;
  logic               out_valid;
  int n_checks = 0;
  int n_fail = 0;
  int win_i[$];
  int win_q[$];
  int exp_i = 0, exp_q = 0;
  bit exp_v = 1'b0;

  quadrature_mixer_dump #(.DATA_W(16), .DECIM(DECIM)) dut (
    .clk(clk), .rst(rst), .lo_i(lo_i), .lo_q(lo_q), .din(din),
    .din_valid(din_valid), .clear(clear), .i_out(i_out), .q_out(q_out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    amp;
    bit    follow_i;
    bit    lo_zero;
    bit    half_duty;
    int    ei;
    int    eq;
    int    ecyc;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference: collect each accepted product in a window list, publish its plain sum when full
  task automatic model(input int d, input bit li, input bit lq, input bit v, input bit c);
    exp_v = 1'b0;
    if (!rst) begin
      win_i.delete(); win_q.delete();
      exp_i = 0; exp_q = 0;
    end else if (c) begin
      win_i.delete(); win_q.delete();
    end else if (v) begin
      win_i.push_back(li ? d : -d);
      win_q.push_back(lq ? d : -d);
      if (win_i.size() == DECIM) begin
        exp_i = 0; exp_q = 0;
        foreach (win_i[k]) exp_i += win_i[k];
        foreach (win_q[k]) exp_q += win_q[k];
        exp_v = 1'b1;
        win_i.delete(); win_q.delete();
      end
    end
  endtask

  task automatic cycle(input int d, input bit li, input bit lq, input bit v, input bit c);
    din = 16'(d); lo_i = li; lo_q = lq; din_valid = v; clear = c;
    @(posedge clk);
    #1;
    model(d, li, lq, v, c);
    chk("out_valid", int'(out_valid), int'(exp_v));
    chk("i_out", int'(i_out), exp_i);
    chk("q_out", int'(q_out), exp_q);
  endtask

  function automatic bit ph_i(input int p); return (p % 4) < 2; endfunction
  function automatic bit ph_q(input int p); return (p % 4) == 1 || (p % 4) == 2; endfunction

  // n samples of +/-100 following lo_i; clear optionally asserted on the last one
  task automatic samples(input int n, input bit clr_last, output int pulses);
    pulses = 0;
    for (int p = 0; p < n; p++) begin
      cycle(ph_i(p) ? 100 : -100, ph_i(p), ph_q(p), 1'b1, clr_last && p == n - 1);
      if (out_valid) pulses++;
    end
  endtask

  vec_t vecs[5];
  int pulses;

  initial begin
    vecs[0] = '{"const100",   100,    1'b0, 1'b0, 1'b0, 0,      0,      16};
    vecs[1] = '{"follow_i",   100,    1'b1, 1'b0, 1'b0, 1600,   0,      16};
    vecs[2] = '{"repeat",     100,    1'b1, 1'b0, 1'b0, 1600,   0,      16};
    vecs[3] = '{"min_neg",    -32768, 1'b0, 1'b1, 1'b0, 524288, 524288, 16};
    vecs[4] = '{"half_duty",  100,    1'b1, 1'b0, 1'b1, 1600,   0,      32};

    for (int k = 0; k < 4; k++) cycle((k % 2) ? -1234 : 1234, ph_i(k), ph_q(k), 1'b1, 1'b0);
    rst = 1'b1;

    foreach (vecs[n]) begin
      int p;
      bit seen;
      p = 0;
      seen = 1'b0;
      for (int cyc = 1; cyc <= 64 && !seen; cyc++) begin
        bit v, li, lq;
        int d;
        v  = vecs[n].half_duty ? (cyc % 2 == 0) : 1'b1;
        li = vecs[n].lo_zero ? 1'b0 : ph_i(p);
        lq = vecs[n].lo_zero ? 1'b0 : ph_q(p);
        d  = (vecs[n].follow_i && !li) ? -vecs[n].amp : vecs[n].amp;
        cycle(d, li, lq, v, 1'b0);
        if (v) p++;
        if (out_valid) begin
          seen = 1'b1;
          chk({vecs[n].name, "_cycle"}, cyc, vecs[n].ecyc);
          chk({vecs[n].name, "_i"}, int'(i_out), vecs[n].ei);
          chk({vecs[n].name, "_q"}, int'(q_out), vecs[n].eq);
        end
      end
      if (!seen) begin
        n_checks++; n_fail++;
        $display("FAIL %s_timeout: no out_valid within 64 cycles", vecs[n].name);
      end
      cycle(0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk({vecs[n].name, "_pulse_width"}, int'(out_valid), 0);
    end

    samples(16, 1'b1, pulses);
    chk("clear_on_16th_pulses", pulses, 0);
    samples(16, 1'b0, pulses);
    chk("after_clear_pulses", pulses, 1);
    chk("after_clear_i", int'(i_out), 1600);

    samples(8, 1'b0, pulses);
    rst = 1'b0;
    #1;
    chk("async_rst_i", int'(i_out), 0);
    chk("async_rst_valid", int'(out_valid), 0);
    cycle(100, 1'b1, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    samples(15, 1'b0, pulses);
    chk("post_rst_15_pulses", pulses, 0);
    cycle(-100, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("post_rst_16_valid", int'(out_valid), 1);
    chk("post_rst_16_i", int'(i_out), 1600);

    for (int k = 0; k < 600; k++)
      cycle(int'($signed(16'($urandom))), 1'($urandom), 1'($urandom),
            $urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
